// File: rtl/eee_colour_bbox_multi_if.sv
// Avalon-ST video beat bundle: 24-bit RGB data with packet framing and back-pressure.
interface eee_colour_bbox_multi_if;
    logic [23:0] data;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        ready;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/eee_colour_bbox_multi.sv
// Multi-colour bounding-box tracker on an Avalon-ST RGB stream, with optional box overlay.
// One lane per colour classifies the pixel and accumulates a box and a match count;
// the top tracks packet type and pixel coordinates and owns the single output register.

module eee_colour_bbox_multi_lane #(
    parameter int COORD_W = 11,
    parameter int CNT_W   = 20,
    parameter int MIN_PIX = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clr,      // video SOP accepted: restart frame
    input  logic                 i_pix,      // video pixel accepted
    input  logic                 i_latch,    // video EOP pixel accepted
    input  logic [23:0]          i_rgb,
    input  logic [23:0]          i_lo,
    input  logic [23:0]          i_hi,
    input  logic [COORD_W-1:0]   i_x,
    input  logic [COORD_W-1:0]   i_y,
    output logic [4*COORD_W-1:0] o_bbox,     // {xmin,xmax,ymin,ymax}
    output logic [CNT_W-1:0]     o_cnt,
    output logic                 o_valid,
    output logic                 o_hit       // (x,y) on the latched box perimeter
);
    logic [23:0]        r_lo, r_hi;
    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_match, w_upd;
    logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic [CNT_W-1:0]   w_cnt;
    logic [COORD_W-1:0] w_lxmin, w_lxmax, w_lymin, w_lymax;

    assign w_match = (i_rgb[23:16] >= r_lo[23:16]) && (i_rgb[23:16] <= r_hi[23:16]) &&
                     (i_rgb[15:8]  >= r_lo[15:8])  && (i_rgb[15:8]  <= r_hi[15:8])  &&
                     (i_rgb[7:0]   >= r_lo[7:0])   && (i_rgb[7:0]   <= r_hi[7:0]);
    assign w_upd   = i_pix & w_match;

    // Accumulator values including the current beat, so the EOP pixel is part of the result.
    assign w_xmin = (w_upd && i_x < r_xmin) ? i_x : r_xmin;
    assign w_xmax = (w_upd && i_x > r_xmax) ? i_x : r_xmax;
    assign w_ymin = (w_upd && i_y < r_ymin) ? i_y : r_ymin;
    assign w_ymax = (w_upd && i_y > r_ymax) ? i_y : r_ymax;
    assign w_cnt  = (w_upd && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;

    // Threshold snapshot and per-frame accumulation; empty box is min=all-ones, max=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_lo   <= i_lo;
            r_hi   <= i_hi;
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else if (i_pix) begin
            r_xmin <= w_xmin;
            r_xmax <= w_xmax;
            r_ymin <= w_ymin;
            r_ymax <= w_ymax;
            r_cnt  <= w_cnt;
        end
    end

    // Results copied out at end of frame and held until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_bbox  <= '0;
            o_cnt   <= '0;
            o_valid <= 1'b0;
        end else if (i_latch) begin
            o_bbox  <= {w_xmin, w_xmax, w_ymin, w_ymax};
            o_cnt   <= w_cnt;
            o_valid <= (w_cnt != '0) && (w_cnt >= CNT_W'(MIN_PIX));
        end
    end

    assign w_lxmin = o_bbox[4*COORD_W-1 -: COORD_W];
    assign w_lxmax = o_bbox[3*COORD_W-1 -: COORD_W];
    assign w_lymin = o_bbox[2*COORD_W-1 -: COORD_W];
    assign w_lymax = o_bbox[COORD_W-1:0];

    assign o_hit = o_valid &
                   ((((i_x == w_lxmin) || (i_x == w_lxmax)) && (i_y >= w_lymin) && (i_y <= w_lymax)) ||
                    (((i_y == w_lymin) || (i_y == w_lymax)) && (i_x >= w_lxmin) && (i_x <= w_lxmax)));
endmodule

module eee_colour_bbox_multi #(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter int          N_COLOURS = 4,
    parameter int          COORD_W   = 11,
    parameter int          CNT_W     = 20,
    parameter int          MIN_PIX   = 16,
    parameter logic [23:0] BOX_RGB   = 24'hFFFFFF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    eee_colour_bbox_multi_if.slave         sink,
    eee_colour_bbox_multi_if.master        source,
    input  logic                           mode,
    input  logic [24*N_COLOURS-1:0]        thr_lo,
    input  logic [24*N_COLOURS-1:0]        thr_hi,
    output logic [4*COORD_W*N_COLOURS-1:0] bbox,
    output logic [CNT_W*N_COLOURS-1:0]     pix_cnt,
    output logic [N_COLOURS-1:0]           bbox_valid,
    output logic                           frame_done,
    output logic                           overrun
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    // S_IDLE also covers "just out of reset": beats are passed but never counted.
    typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_OTHER} state_t;

    state_t               r_state, w_state_nxt;
    logic [COORD_W-1:0]   r_x, r_y;
    logic                 r_full;
    logic                 r_src_valid, r_src_sop, r_src_eop;
    logic [23:0]          r_src_data;
    logic                 r_fd, r_overrun;

    logic                 w_acc, w_vid_sop, w_pix, w_latch;
    logic [N_COLOURS-1:0] w_hit;
    logic [23:0]          w_out_pix;

    assign sink.ready = source.ready | ~r_src_valid;
    assign w_acc      = sink.valid & sink.ready;

    // Packet-type state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Decode each accepted beat; a SOP mid-packet simply restarts (abort without latch).
    always_comb begin
        w_state_nxt = r_state;
        w_vid_sop   = 1'b0;
        w_pix       = 1'b0;
        w_latch     = 1'b0;
        if (w_acc) begin
            if (sink.sop) begin
                w_vid_sop = (sink.data[3:0] == 4'h0);
                if (sink.eop)       w_state_nxt = S_IDLE;
                else if (w_vid_sop) w_state_nxt = S_VIDEO;
                else                w_state_nxt = S_OTHER;
            end else begin
                w_pix   = (r_state == S_VIDEO);
                w_latch = w_pix & sink.eop;
                if (sink.eop) w_state_nxt = S_IDLE;
            end
        end
    end

    // Pixel coordinates; y sticks on the last line, and any pixel after a full frame is overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_vid_sop) begin
            r_x       <= '0;
            r_y       <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_pix) begin
            if (r_full) r_overrun <= 1'b1;
            if (r_x == X_LAST) begin
                r_x <= '0;
                if (r_y == Y_LAST) r_full <= 1'b1;
                else               r_y    <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_COLOURS; k++) begin : g_lane
        eee_colour_bbox_multi_lane #(
            .COORD_W (COORD_W),
            .CNT_W   (CNT_W),
            .MIN_PIX (MIN_PIX)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .i_clr   (w_vid_sop),
            .i_pix   (w_pix),
            .i_latch (w_latch),
            .i_rgb   (sink.data),
            .i_lo    (thr_lo[k*24 +: 24]),
            .i_hi    (thr_hi[k*24 +: 24]),
            .i_x     (r_x),
            .i_y     (r_y),
            .o_bbox  (bbox[k*4*COORD_W +: 4*COORD_W]),
            .o_cnt   (pix_cnt[k*CNT_W +: CNT_W]),
            .o_valid (bbox_valid[k]),
            .o_hit   (w_hit[k])
        );
    end

    // Overlay replaces only video pixels; the classifier still sees sink.data.
    assign w_out_pix = (w_pix && mode && (|w_hit)) ? BOX_RGB : sink.data;

    // Single output register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src_valid <= 1'b0;
            r_src_data  <= '0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
        end else if (w_acc) begin
            r_src_valid <= 1'b1;
            r_src_data  <= w_out_pix;
            r_src_sop   <= sink.sop;
            r_src_eop   <= sink.eop;
        end else if (source.ready) begin
            r_src_valid <= 1'b0;
        end
    end

    // frame_done lines up with the newly latched results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fd <= 1'b0;
        else          r_fd <= w_latch;
    end

    assign source.valid = r_src_valid;
    assign source.data  = r_src_data;
    assign source.sop   = r_src_sop;
    assign source.eop   = r_src_eop;
    assign frame_done   = r_fd;
    assign overrun      = r_overrun;
endmodule

// File: tb/tb_eee_colour_bbox_multi.sv
// Directed bench: two instances share one stimulus stream; A is 4x2 (MIN_PIX 16), B is 8x4 (MIN_PIX 1).
module tb_eee_colour_bbox_multi;
    localparam int NC = 4, CW = 11, BW = 4 * CW, CNT_W = 20;
    localparam logic [BW-1:0] EMPTY = {11'h7FF, 11'h000, 11'h7FF, 11'h000};

    logic clk = 1'b0, reset_n = 1'b0, mode = 1'b0, src_ready = 1'b1, rand_rdy = 1'b0;
    logic [23:0] s_data = '0;
    logic s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
    logic [24*NC-1:0] thr_lo, thr_hi;
    logic [BW*NC-1:0] a_bbox, b_bbox;
    logic [CNT_W*NC-1:0] a_cnt, b_cnt;
    logic [NC-1:0] a_bv, b_bv;
    logic a_fd, b_fd, a_ovr, b_ovr;
    int vecs = 0, errs = 0, fd_cnt = 0;
    logic [25:0] exp_q[$], got_q[$];

    eee_colour_bbox_multi_if a_sink();
    eee_colour_bbox_multi_if a_src();
    eee_colour_bbox_multi_if b_sink();
    eee_colour_bbox_multi_if b_src();

    assign a_sink.data = s_data;  assign a_sink.valid = s_valid;
    assign a_sink.sop  = s_sop;   assign a_sink.eop   = s_eop;
    assign b_sink.data = s_data;  assign b_sink.valid = s_valid;
    assign b_sink.sop  = s_sop;   assign b_sink.eop   = s_eop;
    assign a_src.ready = src_ready;
    assign b_src.ready = src_ready;

    eee_colour_bbox_multi #(.WIDTH(4), .HEIGHT(2)) u_a (
        .clk(clk), .reset_n(reset_n), .sink(a_sink), .source(a_src), .mode(mode),
        .thr_lo(thr_lo), .thr_hi(thr_hi), .bbox(a_bbox), .pix_cnt(a_cnt),
        .bbox_valid(a_bv), .frame_done(a_fd), .overrun(a_ovr));

    eee_colour_bbox_multi #(.WIDTH(8), .HEIGHT(4), .MIN_PIX(1)) u_b (
        .clk(clk), .reset_n(reset_n), .sink(b_sink), .source(b_src), .mode(mode),
        .thr_lo(thr_lo), .thr_hi(thr_hi), .bbox(b_bbox), .pix_cnt(b_cnt),
        .bbox_valid(b_bv), .frame_done(b_fd), .overrun(b_ovr));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk); #1;
            src_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (b_src.valid && src_ready) got_q.push_back({b_src.sop, b_src.eop, b_src.data});
            if (b_fd) fd_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic send(input logic [23:0] d, input logic sp, input logic ep, input logic [23:0] ed);
        int n = 0;
        @(negedge clk);
        s_data = d; s_sop = sp; s_eop = ep; s_valid = 1'b1;
        while (!b_sink.ready && n < 200) begin @(negedge clk); n++; end
        if (!b_sink.ready) begin
            vecs++; errs++;
            $display("FAIL send_timeout: sink_ready low for %0d cycles, need 1", n);
        end
        @(posedge clk);
        exp_q.push_back({sp, ep, ed});
    endtask

    task automatic send_pkt(input logic [23:0] hdr, input logic [23:0] px[$], input logic [23:0] ex[$]);
        send(hdr, 1'b1, px.size() == 0, hdr);
        foreach (px[i]) send(px[i], 1'b0, i == px.size() - 1, ex[i]);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic flush();
        repeat (4) @(negedge clk);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic drain();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 400) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vecs++; if (b_bbox !== '0 || a_bbox !== '0) begin errs++; $display("FAIL rst_bbox got %h/%h want 0", a_bbox, b_bbox); end
        vecs++; if (b_cnt !== '0 || b_bv !== '0) begin errs++; $display("FAIL rst_cnt got %h/%h want 0", b_cnt, b_bv); end
        vecs++; if ({a_fd, b_fd, a_ovr, b_ovr, b_src.valid} !== 5'b0) begin errs++; $display("FAIL rst_flags got %b want 00000", {a_fd, b_fd, a_ovr, b_ovr, b_src.valid}); end
        reset_n = 1'b1;
    endtask

    task automatic test_frame_4x2();
        logic [23:0] px[$];
        int fd0;
        thr_lo = {NC{24'hFFFFFF}}; thr_hi = '0;
        thr_lo[23:0] = 24'h000000; thr_hi[23:0] = 24'h101010;
        flush();
        fd0 = fd_cnt;
        for (int i = 0; i < 8; i++) px.push_back(24'h000000);
        send_pkt(24'h000000, px, px);
        @(negedge clk);
        s_valid = 1'b0; s_eop = 1'b0;
        vecs++; if (b_fd !== 1'b1) begin errs++; $display("FAIL fd_pulse got %b want 1", b_fd); end
        @(negedge clk);
        vecs++; if (b_fd !== 1'b0) begin errs++; $display("FAIL fd_width got %b want 0", b_fd); end
        vecs++; if (fd_cnt - fd0 !== 1) begin errs++; $display("FAIL fd_count got %0d want 1", fd_cnt - fd0); end
        vecs++; if (a_bbox[BW-1:0] !== {11'd0, 11'd3, 11'd0, 11'd1}) begin errs++; $display("FAIL a_bbox0 got %h want {0,3,0,1}", a_bbox[BW-1:0]); end
        vecs++; if (a_cnt[CNT_W-1:0] !== 20'd8) begin errs++; $display("FAIL a_cnt0 got %0d want 8", a_cnt[CNT_W-1:0]); end
        vecs++; if (a_bv !== 4'b0000) begin errs++; $display("FAIL a_valid (8<16) got %b want 0000", a_bv); end
        vecs++; if (a_bbox[BW +: BW] !== EMPTY) begin errs++; $display("FAIL a_bbox1_empty got %h want %h", a_bbox[BW +: BW], EMPTY); end
        vecs++; if (a_ovr !== 1'b0) begin errs++; $display("FAIL a_ovr_exact got %b want 0", a_ovr); end
        vecs++; if (b_bbox[BW-1:0] !== {11'd0, 11'd7, 11'd0, 11'd0}) begin errs++; $display("FAIL b_bbox0 got %h want {0,7,0,0}", b_bbox[BW-1:0]); end
        vecs++; if (b_bv !== 4'b0001) begin errs++; $display("FAIL b_valid got %b want 0001", b_bv); end
        drain();
        vecs++; if (got_q !== exp_q) begin errs++; $display("FAIL frame_stream got %0d beats want %0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_single_red();
        logic [23:0] px[$];
        thr_lo[47:24] = 24'hC00000; thr_hi[47:24] = 24'hFF4040;
        flush();
        for (int i = 0; i < 32; i++) px.push_back(i == 29 ? 24'hFF0000 : 24'h808080);
        send_pkt(24'h000000, px, px);
        idle();
        repeat (2) @(negedge clk);
        vecs++; if (b_bbox[BW +: BW] !== {11'd5, 11'd5, 11'd3, 11'd3}) begin errs++; $display("FAIL red_bbox1 got %h want {5,5,3,3}", b_bbox[BW +: BW]); end
        vecs++; if (b_cnt[CNT_W +: CNT_W] !== 20'd1) begin errs++; $display("FAIL red_cnt1 got %0d want 1", b_cnt[CNT_W +: CNT_W]); end
        vecs++; if (b_bv !== 4'b0010) begin errs++; $display("FAIL red_valid got %b want 0010", b_bv); end
        vecs++; if (b_bbox[BW-1:0] !== EMPTY) begin errs++; $display("FAIL red_bbox0_empty got %h want %h", b_bbox[BW-1:0], EMPTY); end
        vecs++; if (a_ovr !== 1'b1 || b_ovr !== 1'b0) begin errs++; $display("FAIL red_ovr got a=%b b=%b want a=1 b=0", a_ovr, b_ovr); end
    endtask

    task automatic test_control();
        logic [23:0] px[$];
        logic [BW*NC-1:0] bb0;
        int fd0;
        flush();
        bb0 = b_bbox; fd0 = fd_cnt;
        px.push_back(24'hFF0000); px.push_back(24'h00000F);
        send_pkt(24'h00000F, px, px);
        idle();
        drain();
        vecs++; if (got_q !== exp_q) begin errs++; $display("FAIL ctrl_stream got %0d beats want %0d", got_q.size(), exp_q.size()); end
        vecs++; if (b_bbox !== bb0 || b_bv !== 4'b0010) begin errs++; $display("FAIL ctrl_results got %h/%b want %h/0010", b_bbox, b_bv, bb0); end
        vecs++; if (fd_cnt !== fd0) begin errs++; $display("FAIL ctrl_fd got %0d pulses want 0", fd_cnt - fd0); end
        vecs++; if (a_ovr !== 1'b1) begin errs++; $display("FAIL ctrl_ovr_sticky got %b want 1", a_ovr); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] px[$], cx[$];
        logic [7:0] b;
        flush();
        rand_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin b = 8'(i); px.push_back({b, 8'h55, 8'hFF - b}); end
        send_pkt(24'h000000, px, px);
        cx.push_back(24'h0A0B0C);
        send_pkt(24'h00000F, cx, cx);
        idle();
        drain();
        rand_rdy = 1'b0;
        vecs++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vecs++;
            if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL b2b_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vecs++; if (b_bv !== 4'b0000 || b_bbox[BW +: BW] !== EMPTY) begin errs++; $display("FAIL zero_match got %b/%h want 0000/%h", b_bv, b_bbox[BW +: BW], EMPTY); end
        vecs++; if (b_cnt !== '0) begin errs++; $display("FAIL zero_cnt got %h want 0", b_cnt); end
    endtask

    task automatic test_overlay();
        logic [23:0] px[$], ex[$];
        int x, y;
        flush();
        for (int i = 0; i < 32; i++) px.push_back((i == 1 || i == 2 || i == 9 || i == 10) ? 24'h000000 : 24'h808080);
        send_pkt(24'h000000, px, px);
        idle();
        repeat (2) @(negedge clk);
        vecs++; if (b_bbox[BW-1:0] !== {11'd1, 11'd2, 11'd0, 11'd1} || b_bv !== 4'b0001) begin errs++; $display("FAIL ovl_setup got %h/%b want {1,2,0,1}/0001", b_bbox[BW-1:0], b_bv); end
        flush();
        mode = 1'b1;
        px.delete();
        for (int i = 0; i < 32; i++) begin
            x = i % 8; y = i / 8;
            px.push_back(i == 1 ? 24'h000000 : 24'h404040);
            ex.push_back(((x == 1 || x == 2) && y <= 1) ? 24'hFFFFFF : px[i]);
        end
        send_pkt(24'h000000, px, ex);
        idle();
        drain();
        mode = 1'b0;
        vecs++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL ovl_len got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vecs++;
            if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL ovl_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vecs++; if (b_bbox[BW-1:0] !== {11'd1, 11'd1, 11'd0, 11'd0} || b_cnt[CNT_W-1:0] !== 20'd1) begin errs++; $display("FAIL ovl_classify_orig got %h/%0d want {1,1,0,0}/1", b_bbox[BW-1:0], b_cnt[CNT_W-1:0]); end
    endtask

    task automatic test_overrun_reset();
        logic [23:0] px[$];
        int fd0;
        flush();
        for (int i = 0; i < 13; i++) px.push_back(24'h000000);
        send_pkt(24'h000000, px, px);
        idle();
        vecs++; if (a_ovr !== 1'b1 || b_ovr !== 1'b0) begin errs++; $display("FAIL ovr_13 got a=%b b=%b want a=1 b=0", a_ovr, b_ovr); end
        send(24'h000000, 1'b1, 1'b0, 24'h000000);
        idle();
        vecs++; if (a_ovr !== 1'b0) begin errs++; $display("FAIL ovr_clear_sop got %b want 0", a_ovr); end
        send(24'h000000, 1'b0, 1'b0, 24'h000000);
        send(24'h000000, 1'b0, 1'b0, 24'h000000);
        @(negedge clk);
        s_valid = 1'b0; reset_n = 1'b0;
        #1;
        vecs++; if (a_bbox !== '0 || b_bbox !== '0 || a_cnt !== '0 || b_cnt !== '0) begin errs++; $display("FAIL midrst_results got %h/%h want 0", b_bbox, b_cnt); end
        vecs++; if ({a_bv, b_bv} !== 8'h00 || {a_fd, b_fd, a_ovr, b_ovr, b_src.valid} !== 5'b0) begin errs++; $display("FAIL midrst_flags got %b/%b want 0", {a_bv, b_bv}, {a_fd, b_fd, a_ovr, b_ovr, b_src.valid}); end
        @(negedge clk);
        reset_n = 1'b1;
        fd0 = fd_cnt;
        send(24'h000000, 1'b0, 1'b1, 24'h000000);
        idle();
        repeat (3) @(negedge clk);
        vecs++; if (fd_cnt !== fd0 || b_cnt !== '0 || b_bv !== '0) begin errs++; $display("FAIL postrst_ignore got fd=%0d cnt=%h want fd=0 cnt=0", fd_cnt - fd0, b_cnt); end
    endtask

    initial begin
        thr_lo = {NC{24'hFFFFFF}};
        thr_hi = '0;
        test_reset();
        test_frame_4x2();
        test_single_red();
        test_control();
        test_back_to_back();
        test_overlay();
        test_overrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
